uart_deserialize: RTL and testbench

UART_DESERIALIZE -- requirements
Module: uart_deserialize

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_sync.sv | 13 +
 rtl/uart_deserialize.sv | 102 ++++++++++
 tb/tb_uart_deserialize.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default frame geometry
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_state_e;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);
  logic meta_q, sync_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) {sync_q, meta_q} <= 2'b11;
    else {sync_q, meta_q} <= {meta_q, async_i};
  assign sync_o = sync_q;
endmodule

// File: rtl/uart_deserialize.sv
// uart_deserialize: oversampled UART receiver with even parity, break detection and a one-deep holding register
module uart_deserialize
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 sample_tick,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_read,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  uart_state_e state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic rx_s, cnt_mid, cnt_end, last_bit;
  logic par_err_q, stop_err_q, commit_q, dv_q, pe_q, fe_q, ov_q;
  uart_rx_sync u_sync (.clock(clock), .reset(reset), .async_i(rx), .sync_o(rx_s));
  assign cnt_mid = cnt_q == CW'(OVERSAMPLE/2 - 1);
  assign cnt_end = cnt_q == CW'(OVERSAMPLE - 1);
  assign cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
  assign last_bit = idx_q == IW'(DATA_BITS - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      par_err_q <= 1'b0;
      stop_err_q <= 1'b0;
      commit_q <= 1'b0;
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (sample_tick)
        case (state_q)
          IDLE: if (!rx_s) begin
            state_q <= START;
            cnt_q <= '0;
          end
          START: if (cnt_mid) begin
            state_q <= rx_s ? IDLE : DATA;
            cnt_q <= '0;
            idx_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
          DATA: begin
            cnt_q <= cnt_d;
            if (cnt_end) begin
              shift_q[idx_q] <= rx_s;
              idx_q <= last_bit ? '0 : idx_q + 1'b1;
              if (last_bit) state_q <= PARITY;
            end
          end
          PARITY: begin
            cnt_q <= cnt_d;
            if (cnt_end) begin
              par_err_q <= ^shift_q ^ rx_s;
              state_q <= STOP;
            end
          end
          STOP: begin
            cnt_q <= cnt_d;
            if (cnt_end) begin
              commit_q <= 1'b1;
              stop_err_q <= ~rx_s;
              state_q <= rx_s ? IDLE : BREAK;
            end
          end
          BREAK: if (rx_s) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      // An unread frame wins over a new one unless it is consumed on the same clock
      if (commit_q && dv_q && !data_read) ov_q <= 1'b1;
      else if (commit_q) begin
        data_q <= shift_q;
        pe_q <= par_err_q;
        fe_q <= stop_err_q;
        dv_q <= 1'b1;
      end else if (data_read) dv_q <= 1'b0;
    end
  end
  assign data = data_q;
  assign data_valid = dv_q;
  assign parity_error = pe_q;
  assign framing_error = fe_q;
  assign overrun = ov_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_deserialize.sv
// tb_uart_deserialize: directed frames with hand-computed expectations for uart_deserialize
module tb_uart_deserialize;
  import uart_pkg::FRAME_BITS;
  localparam int OS = 16;
  localparam int DB = 8;
  localparam int BIT_CLKS = 2 * OS;
  logic clock = 1'b0, reset = 1'b1, rx = 1'b1, sample_tick = 1'b0, data_read = 1'b0;
  logic [DB-1:0] data;
  logic data_valid, parity_error, framing_error, overrun, busy;
  int errors = 0, checks = 0;
  int cyc = 0, rise_cnt = 0, rise_cyc = 0, start_cyc = 0, lat = 0, r0 = 0;
  logic [1:0] tick_hist = 2'b00, rise_hist = 2'b00;
  logic dv_prev = 1'b0;
  uart_deserialize #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clock(clock), .reset(reset), .rx(rx), .sample_tick(sample_tick),
    .data(data), .data_valid(data_valid), .data_read(data_read),
    .parity_error(parity_error), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );
  always #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    #1 sample_tick = ~sample_tick;
  end
  always @(posedge clock) tick_hist <= {tick_hist[0], sample_tick};
  always @(negedge clock) begin
    cyc <= cyc + 1;
    dv_prev <= data_valid;
    if (data_valid && !dv_prev) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
      rise_hist <= tick_hist;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n * BIT_CLKS) @(negedge clock);
  endtask
  task automatic align();
    @(negedge clock);
    while (sample_tick !== 1'b0) @(negedge clock);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int nstop);
    drive_bit(1'b0, 1);
    for (int i = 0; i < DB; i++) drive_bit(d[i], 1);
    drive_bit(par, 1);
    drive_bit(stop, nstop);
  endtask
  task automatic read_pulse();
    data_read = 1'b1;
    @(negedge clock);
    data_read = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_perr", parity_error, 0);
    check("rst_ferr", framing_error, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    drive_bit(1'b1, FRAME_BITS);
    align();
    start_cyc = cyc;
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    check("a5_data", data, 8'hA5);
    check("a5_valid", data_valid, 1);
    check("a5_perr", parity_error, 0);
    check("a5_ferr", framing_error, 0);
    check("a5_busy", busy, 0);
    check("a5_rises", rise_cnt - r0, 1);
    check("a5_commit_after_tick", rise_hist, 2'b10);
    lat = rise_cyc - start_cyc;
    read_pulse();
    @(negedge clock);
    check("a5_read_clears", data_valid, 0);
    send_frame(8'h01, 1'b0, 1'b1, 1);
    check("01_data", data, 8'h01);
    check("01_perr", parity_error, 1);
    check("01_ferr", framing_error, 0);
    read_pulse();
    send_frame(8'h3C, 1'b0, 1'b0, 2);
    check("3c_break_busy", busy, 1);
    drive_bit(1'b0, 1);
    check("3c_break_busy2", busy, 1);
    check("3c_data", data, 8'h3C);
    check("3c_ferr", framing_error, 1);
    check("3c_perr", parity_error, 0);
    drive_bit(1'b1, 1);
    check("3c_idle", busy, 0);
    read_pulse();
    align();
    send_frame(8'h55, 1'b0, 1'b1, 1);
    check("55_data", data, 8'h55);
    check("55_valid", data_valid, 1);
    check("55_ferr", framing_error, 0);
    check("55_perr", parity_error, 0);
    read_pulse();
    r0 = rise_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clock);
    rx = 1'b1;
    check("glitch_seen", busy, 1);
    repeat (2 * BIT_CLKS) @(negedge clock);
    check("glitch_valid", data_valid, 0);
    check("glitch_busy", busy, 0);
    check("glitch_perr", parity_error, 0);
    check("glitch_ferr", framing_error, 0);
    check("glitch_ovr", overrun, 0);
    check("glitch_rises", rise_cnt - r0, 0);
    align();
    send_frame(8'h11, 1'b0, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    check("ovr_data", data, 8'h11);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", data_valid, 1);
    align();
    fork
      send_frame(8'h33, 1'b0, 1'b1, 1);
      begin
        repeat (lat - 1) @(negedge clock);
        data_read = 1'b1;
        @(negedge clock);
        data_read = 1'b0;
      end
    join
    check("33_data", data, 8'h33);
    check("33_valid", data_valid, 1);
    check("33_ovr_sticky", overrun, 1);
    align();
    drive_bit(1'b0, 1);
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 1);
    drive_bit(1'b1, 1);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clock);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mrst_data", data, 0);
    check("mrst_valid", data_valid, 0);
    check("mrst_ovr", overrun, 0);
    check("mrst_busy", busy, 0);
    check("mrst_perr", parity_error, 0);
    check("mrst_ferr", framing_error, 0);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    drive_bit(1'b1, 2);
    check("post_rst_idle", data_valid, 0);
    align();
    send_frame(8'hF0, 1'b0, 1'b1, 1);
    check("f0_data", data, 8'hF0);
    check("f0_valid", data_valid, 1);
    check("f0_perr", parity_error, 0);
    check("f0_ferr", framing_error, 0);
    check("f0_ovr", overrun, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
